// File: rtl/system_pio_pkg.sv
// Shared definitions for the system PIO blocks: register addresses and STATUS bit positions.
package system_pio_pkg;

    localparam logic [2:0] PIO_DATA      = 3'd0;
    localparam logic [2:0] PIO_PULSE_LEN = 3'd1;
    localparam logic [2:0] PIO_PULSE     = 3'd2;
    localparam logic [2:0] PIO_STATUS    = 3'd3;
    localparam logic [2:0] PIO_OUTSET    = 3'd4;
    localparam logic [2:0] PIO_OUTCLEAR  = 3'd5;

    localparam int unsigned STATUS_BUSY_BIT = 0;
    localparam int unsigned STATUS_DONE_BIT = 1;

endpackage

// File: rtl/system_pio_pulse_timer.sv
// Shared one-shot pulse timer: a load (re)starts the down-counter and ORs new bits into the mask.
module system_pio_pulse_timer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [CNT_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] mask_in,
    output logic [DATA_WIDTH-1:0] pulse_mask,
    output logic                  busy,
    output logic                  done_set
);

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [DATA_WIDTH-1:0] mask_q, mask_d;

    assign busy     = (count_q != '0);
    // A load in the final cycle takes priority over the expiry.
    assign done_set = !load && (count_q == CNT_WIDTH'(1));

    always_comb begin
        count_d = count_q;
        mask_d  = mask_q;
        if (load) begin
            count_d = len;
            mask_d  = mask_q | mask_in;
        end else if (busy) begin
            count_d = count_q - CNT_WIDTH'(1);
            if (done_set) begin
                mask_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            mask_q  <= '0;
        end else begin
            count_q <= count_d;
            mask_q  <= mask_d;
        end
    end

    assign pulse_mask = mask_q;

endmodule

// File: rtl/system_pio_output.sv
// Avalon-MM general-purpose output port with set/clear access and a shared timed pulse facility.
module system_pio_output
    import system_pio_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH  = 8,
    parameter int unsigned           CNT_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CNT_WIDTH-1:0]  len_q, len_d;
    logic                  done_q, done_d;
    logic [31:0]           rd_q, rd_d;

    logic                  wr;
    logic [DATA_WIDTH-1:0] wd;
    logic                  pulse_load;
    logic [DATA_WIDTH-1:0] pulse_mask;
    logic                  busy;
    logic                  done_set;
    logic                  unused_wd;

    assign wr        = chipselect && !write_n;
    assign wd        = writedata[DATA_WIDTH-1:0];
    assign unused_wd = ^writedata;

    // Zero-length or empty-mask pulse requests are dropped entirely.
    assign pulse_load = wr && (address == PIO_PULSE) && (len_q != '0) && (wd != '0);

    system_pio_pulse_timer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_pulse_timer (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (pulse_load),
        .len        (len_q),
        .mask_in    (wd),
        .pulse_mask (pulse_mask),
        .busy       (busy),
        .done_set   (done_set)
    );

    always_comb begin
        data_d = data_q;
        len_d  = len_q;
        done_d = done_q;
        if (wr) begin
            case (address)
                PIO_DATA:      data_d = wd;
                PIO_PULSE_LEN: len_d  = writedata[CNT_WIDTH-1:0];
                PIO_STATUS:    done_d = 1'b0;
                PIO_OUTSET:    data_d = data_q | wd;
                PIO_OUTCLEAR:  data_d = data_q & ~wd;
                default:       ;
            endcase
        end
        // Expiry beats a coincident STATUS clear.
        if (done_set) begin
            done_d = 1'b1;
        end
    end

    always_comb begin
        rd_d = '0;
        case (address)
            PIO_DATA:      rd_d[DATA_WIDTH-1:0] = data_q;
            PIO_PULSE_LEN: rd_d[CNT_WIDTH-1:0]  = len_q;
            PIO_PULSE:     rd_d[DATA_WIDTH-1:0] = pulse_mask;
            PIO_STATUS: begin
                rd_d[STATUS_DONE_BIT] = done_q;
                rd_d[STATUS_BUSY_BIT] = busy;
            end
            default:       ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE;
            len_q  <= '0;
            done_q <= 1'b0;
            rd_q   <= '0;
        end else begin
            data_q <= data_d;
            len_q  <= len_d;
            done_q <= done_d;
            rd_q   <= rd_d;
        end
    end

    assign readdata = rd_q;
    assign out_port = data_q | pulse_mask;
    assign irq      = done_q;

endmodule

// File: tb/tb_system_pio_output.sv
// Directed plus random bench for system_pio_output against a time-stamped behavioural model.
module tb_system_pio_output;

    localparam logic [7:0] RV = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  address = '0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    system_pio_output #(
        .DATA_WIDTH  (8),
        .CNT_WIDTH   (16),
        .RESET_VALUE (RV)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Model: pulses tracked by the absolute edge number at which they end.
    logic [7:0]  m_data, m_mask;
    logic [15:0] m_len;
    logic        m_done;
    logic [31:0] m_rd;
    longint      cyc = 0;
    longint      m_end = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_data = RV;
        m_mask = '0;
        m_len  = '0;
        m_done = 1'b0;
        m_rd   = '0;
        m_end  = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_port"}, {24'b0, out_port}, {24'b0, (m_data | m_mask)});
        check({tag, ".irq"}, {31'b0, irq}, {31'b0, m_done});
        check({tag, ".readdata"}, readdata, m_rd);
    endtask

    // Present one bus cycle, advance one edge, update the model, compare.
    task automatic step(input string tag, input logic [2:0] a, input logic cs, input logic wn,
                        input logic [31:0] wd);
        logic [7:0] w;
        logic       wr, pulse_ok, busy_pre;
        address    = a;
        chipselect = cs;
        write_n    = wn;
        writedata  = wd;
        @(posedge clk);
        cyc++;
        w        = wd[7:0];
        wr       = cs && !wn;
        busy_pre = (m_end >= cyc);
        case (a)
            3'd0:    m_rd = {24'b0, m_data};
            3'd1:    m_rd = {16'b0, m_len};
            3'd2:    m_rd = {24'b0, m_mask};
            3'd3:    m_rd = {30'b0, m_done, busy_pre};
            default: m_rd = '0;
        endcase
        pulse_ok = wr && (a == 3'd2) && (m_len != 0) && (w != 0);
        if (wr) begin
            case (a)
                3'd0:    m_data = w;
                3'd1:    m_len = wd[15:0];
                3'd3:    m_done = 1'b0;
                3'd4:    m_data = m_data | w;
                3'd5:    m_data = m_data & ~w;
                default: ;
            endcase
        end
        if (pulse_ok) begin
            m_mask = m_mask | w;
            m_end  = cyc + longint'(m_len);
        end else if (m_end == cyc) begin
            m_mask = '0;
            m_done = 1'b1;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic wr_reg(input string tag, input logic [2:0] a, input logic [31:0] wd);
        step(tag, a, 1'b1, 1'b0, wd);
    endtask

    task automatic rd_reg(input string tag, input logic [2:0] a);
        step(tag, a, 1'b1, 1'b1, 32'h0);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 3'd7, 1'b0, 1'b1, $urandom);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check({tag, ".rst_out"}, {24'b0, out_port}, {24'b0, RV});
        check({tag, ".rst_rd"}, readdata, 32'h0);
        check({tag, ".rst_irq"}, {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("init.out_port", {24'b0, out_port}, {24'b0, RV});
        check("init.readdata", readdata, 32'h0);
        check("init.irq", {31'b0, irq}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Set/clear
        wr_reg("data", 3'd0, 32'hFFFF_FF0F);
        wr_reg("outset", 3'd4, 32'h30);
        wr_reg("outclr", 3'd5, 32'h05);
        check("setclr.lit", {24'b0, out_port}, 32'h3A);
        rd_reg("rd_data", 3'd0);
        check("rd_data.lit", readdata, 32'h3A);

        // Basic pulse
        wr_reg("plen4", 3'd1, 32'd4);
        wr_reg("data0", 3'd0, 32'h0);
        wr_reg("pulse81", 3'd2, 32'h81);
        check("pulse.lit", {24'b0, out_port}, 32'h81);
        idle("pulse_run", 6);
        check("pulse.irq_lit", {31'b0, irq}, 32'h1);
        rd_reg("rd_status", 3'd3);
        check("status.lit", readdata, 32'h2);
        wr_reg("clr_status", 3'd3, 32'h0);
        check("clr.irq_lit", {31'b0, irq}, 32'h0);

        // Retrigger
        wr_reg("plen5", 3'd1, 32'd5);
        wr_reg("pulse01", 3'd2, 32'h01);
        idle("retrig_gap", 2);
        wr_reg("pulse02", 3'd2, 32'h02);
        check("retrig.lit", {24'b0, out_port}, 32'h03);
        idle("retrig_run", 7);
        wr_reg("clr_status2", 3'd3, 32'h0);

        // Zero length is ignored
        wr_reg("plen0", 3'd1, 32'd0);
        wr_reg("pulse_len0", 3'd2, 32'hFF);
        rd_reg("rd_status0", 3'd3);
        check("len0.lit", readdata, 32'h0);

        // Pulse written exactly in the expiry cycle
        wr_reg("plen3", 3'd1, 32'd3);
        wr_reg("pulse10", 3'd2, 32'h10);
        idle("exp_gap", 2);
        wr_reg("pulse20_exp", 3'd2, 32'h20);
        check("extend.lit", {24'b0, out_port}, 32'h30);
        check("extend.irq_lit", {31'b0, irq}, 32'h0);
        idle("extend_run", 5);
        wr_reg("clr_status3", 3'd3, 32'h0);

        // STATUS clear coincident with expiry
        wr_reg("pulse04", 3'd2, 32'h04);
        idle("stat_gap", 2);
        wr_reg("status_at_exp", 3'd3, 32'h0);
        check("setwins.lit", {31'b0, irq}, 32'h1);
        wr_reg("clr_status4", 3'd3, 32'h0);

        // Reset mid-pulse
        wr_reg("plen100", 3'd1, 32'd100);
        wr_reg("pulseFF", 3'd2, 32'hFF);
        idle("long_run", 9);
        do_reset("midpulse");
        rd_reg("rd_status_rst", 3'd3);
        check("rst.busy_lit", readdata, 32'h0);
        idle("post_rst", 110);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            logic [2:0]  a;
            logic [31:0] wd;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd1) wd = $urandom_range(0, 8);
            step("rand", a, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), wd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/system_pio_output.md
# system_pio_output

Avalon-MM slave general-purpose output port, the transmit-side counterpart of the system PIO input block; the CPU drives `out_port` through a data register, atomic bit set/clear, and per-bit timed one-shot pulses. It sits on the system interconnect beside the input PIO and drives board-level strobes and LEDs. It also supports a shared pulse timer with a sticky completion flag and an interrupt.

## Interface
- `DATA_WIDTH`, 8, width of `out_port`, range 1..32.
- `CNT_WIDTH`, 16, pulse-length counter width, range 1..32.
- `RESET_VALUE`, 0, reset value of the data register, `DATA_WIDTH` bits.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `address`  in  3  word address.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe; a write occurs when `chipselect && !write_n`.
- `writedata`  in  32  write data; bits above the register width are ignored.
- `readdata`  out  32  registered read data.
- `out_port`  out  `DATA_WIDTH`  port output, equal to `data_reg | pulse_mask`.
- `irq`  out  1  equals the `done` flag.

## Operation
- **Reset values:** `data_reg` = `RESET_VALUE`; `pulse_len`, `pulse_mask`, `count`, `done` and `readdata` = 0. Consequently `out_port` = `RESET_VALUE` and `irq` = 0.
- **Register map, write side:**
  - 0 DATA: `data_reg` <= `writedata[DATA_WIDTH-1:0]`.
  - 1 PULSE_LEN: `pulse_len` <= `writedata[CNT_WIDTH-1:0]`.
  - 2 PULSE: start or retrigger a pulse (see Pulse timer).
  - 3 STATUS: any write clears `done`.
  - 4 OUTSET: `data_reg` <= `data_reg | wd`.
  - 5 OUTCLEAR: `data_reg` <= `data_reg & ~wd`.
  - 6, 7: no effect.
- **Register map, read side:**
  - 0 returns `data_reg`; 1 returns `pulse_len`; 2 returns `pulse_mask`.
  - 3 returns `{30'b0, done, busy}`, where `busy = (count != 0)`.
  - 4..7 return 0.
  - All read values are zero-extended to 32 bits.
- **Read path:** the read mux is evaluated every cycle, independent of `chipselect`. `readdata` is registered, giving a fixed one-cycle read latency and no wait states.
- **Pulse timer:** one shared down-counter `count` of width `CNT_WIDTH`.
  - A PULSE write with `pulse_len == 0` or `wd == 0` is ignored.
  - Otherwise: `count` <= `pulse_len`; `pulse_mask` <= `pulse_mask | wd`. Retriggering extends all active bits.
  - While `count != 0` and no PULSE write is accepted: `count` decrements each cycle.
  - When `count == 1` decrements to 0: `pulse_mask` <= 0 and `done` <= 1.
  - Net effect: a pulsed bit is forced high for exactly `pulse_len` cycles after the write edge.
- **Simultaneous events:**
  - A PULSE write in the expiry cycle (`count == 1`) wins: reload, mask = old | new, `done` is not set.
  - A STATUS write in the expiry cycle: the set wins, so `done` = 1.
  - A DATA/OUTSET/OUTCLEAR write during a pulse updates `data_reg` only. The pulse continues, and the bit returns to its `data_reg` value on expiry.
- **Reset mid-pulse:** all state is cleared immediately (asynchronously); `out_port` returns to `RESET_VALUE` with no glitch beyond the reset assertion itself.

## Timing
- Write accepted at edge E: the new `out_port` value is visible after E, i.e. one cycle after the write presentation.
- Read presented in cycle N: `readdata` is valid in cycle N+1.
- Pulse written at edge E with `pulse_len = L`: bit high for cycles E..E+L-1.
  - Mask clears and `done` sets at edge E+L.
  - `irq` asserts in the same cycle as the mask clear.
- Back-to-back writes every cycle are accepted; there is no backpressure.

## Structure
- Shared package `system_pio_pkg` holds:
  - the address constants `PIO_DATA`, `PIO_PULSE_LEN`, `PIO_PULSE`, `PIO_STATUS`, `PIO_OUTSET`, `PIO_OUTCLEAR`;
  - the STATUS bit indices.
- One sub-module is natural: `system_pio_pulse_timer`. It takes the load strobe, `len` and `mask_in`, and produces `pulse_mask`, `busy` and the `done_set` strobe.
- Register file, read mux and `done` flag stay at top level.

## Test plan
- **Reset:** `RESET_VALUE = 8'hA5`, assert `reset_n` = 0 mid-run → `out_port = 8'hA5`, `readdata = 0`, `irq = 0`.
- **Set/clear:**
  - write DATA = `8'h0F` → `out_port = 8'h0F`;
  - OUTSET `8'h30` → `8'h3F`;
  - OUTCLEAR `8'h05` → `8'h3A`;
  - read address 0 → `32'h3A` one cycle later.
- **Pulse:** PULSE_LEN = 4, DATA = 0, PULSE `8'h81`.
  - `out_port = 8'h81` for exactly 4 cycles, then `8'h00`.
  - `irq` = 1 at expiry; STATUS reads `32'h2`.
  - Write STATUS → `irq` = 0.
- **Retrigger:** PULSE_LEN = 5, PULSE `8'h01`, then PULSE `8'h02` three cycles later → `8'h03` for 5 cycles after the second write, then `8'h00`. `done` sets once, at the end.
- **Boundaries:**
  - PULSE with PULSE_LEN = 0 → no change, busy = 0.
  - PULSE written exactly in the expiry cycle → no `done`, pulse extended.
  - STATUS write coincident with expiry → `done` = 1.
- **Reset mid-pulse:** PULSE_LEN = 100, PULSE `8'hFF`, assert `reset_n` at cycle 10 → `out_port = RESET_VALUE`, busy = 0; no `irq` after release.
